// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, 16x oversampled; delivers each byte on RxData/RxDone.
// RxSerial is synchronised internally; framing errors pulse FrameErr once per break.
module uart_rx_core #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       RxSerial,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       RxBusy
);

    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic          sync1_q, sync2_q;
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;
    logic          tick;

    assign rx_s = sync2_q;
    assign tick = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = tick ? '0 : baud_q + 1'b1;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    baud_d  = '0;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_q == TICK_MID) begin
                        // a start bit that is high again at mid-bit was a glitch
                        state_d = rx_s ? IDLE : DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d               = '0;
                        // shifting right keeps bits above DATA_BITS at zero
                        shreg_d              = shreg_q >> 1;
                        shreg_d[DATA_BITS-1] = rx_s;
                        bit_d                = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            data_d  = shreg_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            baud_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= RxSerial;
            sync2_q <= sync1_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign RxData   = data_q;
    assign RxDone   = done_q;
    assign FrameErr = ferr_q;
    assign RxBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with BAUD_DIV=4, OVERSAMPLE=16 (64 pClk per bit).
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic       pClk = 1'b0;
    logic       pReset = 1'b0;
    logic       RxSerial = 1'b1;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       RxBusy;

    int tests = 0;
    int fails = 0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          ferr_cnt = 0;
    int          both_cnt = 0;
    logic [7:0]  rx_log[$];
    int          done_cyc[$];

    uart_rx_core #(
        .BAUD_DIV(4),
        .OVERSAMPLE(16),
        .DATA_BITS(8)
    ) dut (
        .pClk(pClk),
        .pReset(pReset),
        .RxSerial(RxSerial),
        .RxData(RxData),
        .RxDone(RxDone),
        .FrameErr(FrameErr),
        .RxBusy(RxBusy)
    );

    always #5 pClk = ~pClk;

    always @(negedge pClk) begin
        cyc = cyc + 1;
        if (RxDone === 1'b1) begin
            done_cnt = done_cnt + 1;
            rx_log.push_back(RxData);
            done_cyc.push_back(cyc);
        end
        if (FrameErr === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (RxDone === 1'b1 && FrameErr === 1'b1) both_cnt = both_cnt + 1;
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop;
        int         bitlen;
        int         hold;
        logic [7:0] exp_data;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        RxSerial = 1'b1;
        repeat (n) @(negedge pClk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bitlen);
        RxSerial = 1'b0;
        repeat (bitlen) @(negedge pClk);
        for (int i = 0; i < 8; i++) begin
            RxSerial = d[i];
            repeat (bitlen) @(negedge pClk);
        end
        RxSerial = stop;
        repeat (bitlen) @(negedge pClk);
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(v.data, v.stop, v.bitlen);
        repeat (v.hold) @(negedge pClk);
        idle(40);
        chk({v.name, "_done"}, 32'(done_cnt - d0), 32'(v.exp_done));
        chk({v.name, "_ferr"}, 32'(ferr_cnt - f0), 32'(v.exp_ferr));
        chk({v.name, "_data"}, 32'(RxData), 32'(v.exp_data));
        chk({v.name, "_busy"}, 32'(RxBusy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int f0;
        int n;
        int q0;

        vecs[0] = '{"a5",      8'hA5, 1'b1, 64,   0, 8'hA5, 1, 0};
        vecs[1] = '{"brk55",   8'h55, 1'b0, 64, 200, 8'hA5, 0, 1};
        vecs[2] = '{"x81",     8'h81, 1'b1, 64,   0, 8'h81, 1, 0};
        vecs[3] = '{"s62_96",  8'h96, 1'b1, 62,   0, 8'h96, 1, 0};
        vecs[4] = '{"s66_4b",  8'h4B, 1'b1, 66,   0, 8'h4B, 1, 0};
        vecs[5] = '{"s62_e7",  8'hE7, 1'b1, 62,   0, 8'hE7, 1, 0};
        vecs[6] = '{"s66_18",  8'h18, 1'b1, 66,   0, 8'h18, 1, 0};
        vecs[7] = '{"s66_c3",  8'hC3, 1'b1, 66,   0, 8'hC3, 1, 0};

        repeat (3) @(negedge pClk);
        chk("rst_data", 32'(RxData), 32'd0);
        chk("rst_done", 32'(RxDone), 32'd0);
        chk("rst_ferr", 32'(FrameErr), 32'd0);
        chk("rst_busy", 32'(RxBusy), 32'd0);
        pReset = 1'b1;
        idle(20);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // start-bit glitch, then a clean frame
        d0 = done_cnt;
        f0 = ferr_cnt;
        RxSerial = 1'b0;
        repeat (20) @(negedge pClk);
        chk("glitch_busy_hi", 32'(RxBusy), 32'd1);
        RxSerial = 1'b1;
        n = 0;
        while (RxBusy === 1'b1 && n < 40) begin
            @(negedge pClk);
            n = n + 1;
        end
        chk("glitch_busy_lo", 32'(RxBusy), 32'd0);
        idle(100);
        chk("glitch_done", 32'(done_cnt - d0), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        run_vec('{"x3c", 8'h3C, 1'b1, 64, 0, 8'h3C, 1, 0});

        // back-to-back frames with a single stop bit
        q0 = rx_log.size();
        send_frame(8'h00, 1'b1, 64);
        send_frame(8'hFF, 1'b1, 64);
        idle(40);
        chk("b2b_count", 32'(rx_log.size() - q0), 32'd2);
        if (rx_log.size() - q0 == 2) begin
            chk("b2b_first", 32'(rx_log[q0]), 32'h00);
            chk("b2b_second", 32'(rx_log[q0+1]), 32'hFF);
            chk("b2b_gap", 32'(done_cyc[q0+1] - done_cyc[q0]), 32'd640);
        end

        // reset in the middle of data bit 4 of 0x5A
        d0 = done_cnt;
        f0 = ferr_cnt;
        RxSerial = 1'b0;
        repeat (64) @(negedge pClk);
        for (int i = 0; i < 4; i++) begin
            RxSerial = (8'h5A >> i) & 8'h01;
            repeat (64) @(negedge pClk);
        end
        RxSerial = 1'b1;
        repeat (32) @(negedge pClk);
        chk("mid_busy", 32'(RxBusy), 32'd1);
        pReset = 1'b0;
        #1;
        chk("mrst_data", 32'(RxData), 32'd0);
        chk("mrst_busy", 32'(RxBusy), 32'd0);
        repeat (4) @(negedge pClk);
        pReset = 1'b1;
        idle(64);
        chk("mrst_done", 32'(done_cnt - d0), 32'd0);
        chk("mrst_ferr", 32'(ferr_cnt - f0), 32'd0);
        run_vec('{"x5a", 8'h5A, 1'b1, 64, 0, 8'h5A, 1, 0});

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
